fifo_wr_arb: RTL and testbench
==============================

Name: fifo_wr_arb

Overview:
- Write-side arbiter that shares the single write port of the asynchronous FIFO among NUM_REQ requesters, all in the write clock domain.
- Round-robin arbitration with burst hold: a grant stays with one requester until it signals end-of-packet, reaches MAX_BURST beats, or goes idle for IDLE_TIMEOUT cycles.
- Drives the FIFO's wdata/winc and obeys its wfull flag. Sits directly in front of the FIFO write port.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 64, data width; must match the FIFO
- MAX_BURST, 4, maximum beats per grant (1..255)
- IDLE_TIMEOUT, 8, consecutive cycles with the granted requester's valid low before the grant is released (1..255)

Ports:
- wclk  in  1  write-domain clock
- wrst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester end-of-packet, qualified by valid
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester accept
- wfull  in  1  FIFO full flag, registered in the FIFO
- winc  out  1  FIFO write enable
- wdata  out  DATA_WIDTH  FIFO write data
- grant_valid  out  1  a grant is held
- grant_id  out  $clog2(NUM_REQ)  index of the current grantee
- beat_cnt  out  8  beats accepted in the current grant

Behaviour:
- Reset (async assert, sync release internally not required): state = IDLE; grant_valid = 0; grant_id = 0; beat_cnt = 0; idle counter = 0; rr pointer = NUM_REQ-1, so requester 0 has highest priority first. While reset is asserted, req_ready = 0 and winc = 0.
- States: IDLE and GRANT.
- IDLE:
  - If any req_valid, the next cycle is GRANT with grant_id = first valid index scanning upward (with wrap) from rr pointer + 1.
  - Arbitration latency is 1 cycle: no data transfers in IDLE.
- GRANT with grantee g:
  - req_ready[g] = ~wfull. All other ready bits are 0.
  - winc = req_valid[g] & ~wfull; wdata = req_data[g]. Both combinational.
  - Transfer = req_valid[g] & req_ready[g]. Each transfer increments beat_cnt.
- Release conditions, evaluated on a transfer cycle:
  - req_last[g] is set, or
  - beat_cnt+1 == MAX_BURST.
- Idle release:
  - The idle counter increments on cycles where req_valid[g] = 0 and clears on any valid cycle.
  - When it reaches IDLE_TIMEOUT the grant is released with no transfer.
  - wfull stall cycles with valid high do not count as idle.
- On release:
  - rr pointer = g; beat_cnt = 0; idle counter = 0.
  - If any other requester, or g itself, is valid in the release cycle, go directly to GRANT of the next round-robin winner with no bubble, using the updated pointer. g has lowest priority. Otherwise go to IDLE.
- winc is never asserted while wfull = 1. A grantee holding valid while full stalls indefinitely; there is no timeout under wfull.
- req_data and req_last of non-granted requesters are ignored.
- A requester may drop valid between beats without losing the grant, unless it hits the idle timeout.
- Single requester continuously valid: it is re-granted back-to-back every MAX_BURST beats without a bubble.
- Reset mid-grant: the grant is abandoned immediately. The in-flight beat is not written unless its winc edge completed before reset.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, GRANT}
  - function rr_next(mask, ptr)
  - constant CNT_W = 8
- Sub-module rr_pick: combinational rotating-priority encoder (valid vector + pointer → found, index). Parameterised on NUM_REQ.
- The FSM, counters and mux stay in fifo_wr_arb.

Test Plan:
- Req 0 only: 3 beats with last on beat 3, wfull = 0 → grant_id = 0 one cycle after valid; winc high 3 consecutive cycles; wdata matches; then IDLE.
- Req 0–3 all valid, streaming without last, MAX_BURST = 4 → grants in order 0,1,2,3,0; 4 beats each; no bubble between grants; beat_cnt wraps 3→0.
- Req 1 granted, wfull asserted for 5 cycles mid-burst → req_ready[1] = 0 and winc = 0 for those 5 cycles; the grant is kept; no timeout; the burst resumes when wfull drops.
- Req 2 granted, then drops valid for 8 cycles with req 3 valid → the grant moves to 3 on the cycle after the 8th idle cycle. Dropping valid for 7 cycles keeps the grant with 2.
- Req 0 and req 1 both valid, with req 1's last on beat 1 while req 0 keeps valid → order 0(4 beats), 1(1 beat), 0. Requester 0 is never starved.
- wrst pulsed mid-burst for req 3 → winc, req_ready, grant_valid and beat_cnt are 0 immediately. After release, requester 0 wins first if it is valid.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// rr_next is written for up to 16 requesters so that a single function serves every NUM_REQ.
package fifo_arb_pkg;

    localparam int CNT_W   = 8;
    localparam int MAX_REQ = 16;
    localparam int PTR_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set bit of mask scanning upward from ptr+1 with wrap at num. ptr itself is checked last.
    function automatic logic [PTR_W-1:0] rr_next(
        input logic [MAX_REQ-1:0] mask,
        input logic [PTR_W-1:0]   ptr,
        input int                 num
    );
        logic [PTR_W-1:0] idx;
        logic             hit;
        int               cand;
        idx = '0;
        hit = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            cand = (int'(ptr) + k) % num;
            if (k <= num && !hit && mask[cand]) begin
                hit = 1'b1;
                idx = PTR_W'(cand);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: the requester just after ptr has the highest priority.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    logic [MAX_REQ-1:0] mask;
    logic [PTR_W-1:0]   pick;

    assign mask  = MAX_REQ'(valid);
    assign pick  = rr_next(mask, PTR_W'(ptr), NUM_REQ);
    assign found = |valid;
    assign index = IDX_W'(pick);

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter with burst hold in front of the async FIFO write port.
// A grant ends on last, on MAX_BURST beats, or after IDLE_TIMEOUT consecutive idle cycles.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int DATA_WIDTH   = 64,
    parameter  int MAX_BURST    = 4,
    parameter  int IDLE_TIMEOUT = 8,
    localparam int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_id,
    output logic [CNT_W-1:0]              beat_cnt
);

    state_t             state;
    logic [IDX_W-1:0]   gid_q;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   beat_q;
    logic [CNT_W-1:0]   idle_q;

    logic               in_grant;
    logic               g_valid;
    logic               g_last;
    logic               xfer;
    logic               burst_done;
    logic               idle_done;
    logic               release_grant;
    logic [CNT_W-1:0]   beat_inc;
    logic [CNT_W-1:0]   idle_inc;
    logic [IDX_W-1:0]   pick_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;

    // Gating with wrst keeps ready/winc low for the whole reset, not only after the state flop clears.
    assign in_grant = (state == GRANT) && !wrst;
    assign g_valid  = req_valid[gid_q];
    assign g_last   = req_last[gid_q];
    assign xfer     = in_grant && g_valid && !wfull;

    assign beat_inc = beat_q + CNT_W'(1);
    assign idle_inc = idle_q + CNT_W'(1);

    assign burst_done    = xfer && (g_last || (beat_inc == CNT_W'(MAX_BURST)));
    assign idle_done     = in_grant && !g_valid && (idle_inc == CNT_W'(IDLE_TIMEOUT));
    assign release_grant = burst_done || idle_done;

    // On release the grantee becomes the pointer, so it scans last among the next candidates.
    assign pick_ptr = (state == GRANT) ? gid_q : rr_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (pick_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        req_ready        = '0;
        req_ready[gid_q] = in_grant && !wfull;
    end

    assign winc        = xfer;
    assign wdata       = req_data[int'(gid_q)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_valid = (state == GRANT);
    assign grant_id    = gid_q;
    assign beat_cnt    = beat_q;

    // NOTE: sequential state uses non-blocking assignments only, so all flops sample the same pre-edge values.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state  <= IDLE;
            gid_q  <= '0;
            rr_ptr <= IDX_W'(NUM_REQ - 1);
            beat_q <= '0;
            idle_q <= '0;
        end else if (state == IDLE) begin
            if (pick_found) begin
                state <= GRANT;
                gid_q <= pick_idx;
            end
        end else begin
            if (release_grant) begin
                rr_ptr <= gid_q;
                beat_q <= '0;
                idle_q <= '0;
                if (pick_found) begin
                    gid_q <= pick_idx;
                end else begin
                    state <= IDLE;
                    gid_q <= '0;
                end
            end else begin
                if (xfer) begin
                    beat_q <= beat_inc;
                end
                // Stall cycles under wfull have valid high, so they never advance the idle count.
                idle_q <= g_valid ? '0 : idle_inc;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomised and directed stimulus for fifo_wr_arb, checked by a scoreboard against a transaction-level model.
// The driver pushes per-cycle expectations and expected FIFO writes; a negedge monitor pops and compares.
module tb_fifo_wr_arb;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int MB  = 4;
    localparam int IDT = 8;

    logic              wclk;
    logic              wrst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_last;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              wfull;
    logic              winc;
    logic [DW-1:0]     wdata;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic [7:0]        beat_cnt;

    fifo_wr_arb #(
        .NUM_REQ      (N),
        .DATA_WIDTH   (DW),
        .MAX_BURST    (MB),
        .IDLE_TIMEOUT (IDT)
    ) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wfull       (wfull),
        .winc        (winc),
        .wdata       (wdata),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .beat_cnt    (beat_cnt)
    );

    typedef struct packed {
        logic       gv;
        logic [1:0] gid;
        logic [7:0] beat;
        logic [3:0] rdy;
        logic       winc;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] wr_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the port, beats granted so far, quiet cycles, last winner.
    bit m_busy;
    int m_owner;
    int m_beats;
    int m_quiet;
    int m_ptr;

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int next_winner(input int after, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(after + k) % N]) return (after + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_beats = 0;
        m_quiet = 0;
        m_ptr   = N - 1;
    endtask

    // Advance the model across one clock edge using the inputs that were present during the cycle.
    task automatic model_step(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
        bit done;
        int w;
        done = 0;
        if (!m_busy) begin
            w = next_winner(m_ptr, v);
            if (w >= 0) begin
                m_busy  = 1;
                m_owner = w;
            end
        end else begin
            if (v[m_owner]) begin
                m_quiet = 0;
                if (!f) begin
                    m_beats++;
                    if (l[m_owner] || m_beats == MB) done = 1;
                end
            end else begin
                m_quiet++;
                if (m_quiet == IDT) done = 1;
            end
            if (done) begin
                m_ptr   = m_owner;
                m_beats = 0;
                m_quiet = 0;
                w = next_winner(m_ptr, v);
                if (w >= 0) m_owner = w;
                else begin
                    m_busy  = 0;
                    m_owner = 0;
                end
            end
        end
    endtask

    task automatic run_cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic f, input logic r);
        exp_t e;
        @(posedge wclk);
        if (wrst) model_reset();
        else model_step(req_valid, req_last, wfull);
        #1;
        wrst      = r;
        req_valid = v;
        req_last  = l;
        wfull     = f;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {$urandom, $urandom};
        if (r) model_reset();
        e.gv   = m_busy;
        e.gid  = m_busy ? 2'(m_owner) : 2'd0;
        e.beat = 8'(m_beats);
        e.rdy  = (m_busy && !f) ? 4'(1 << m_owner) : 4'd0;
        e.winc = m_busy && v[m_owner] && !f;
        exp_q.push_back(e);
        if (e.winc) wr_q.push_back(req_data[m_owner*DW +: DW]);
    endtask

    task automatic repeat_cycle(input int n, input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
        for (int i = 0; i < n; i++) run_cycle(v, l, f, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge wclk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("grant_valid", 64'(grant_valid), 64'(e.gv));
                if (e.gv) check("grant_id", 64'(grant_id), 64'(e.gid));
                check("beat_cnt", 64'(beat_cnt), 64'(e.beat));
                check("req_ready", 64'(req_ready), 64'(e.rdy));
                check("winc", 64'(winc), 64'(e.winc));
                if (winc) begin
                    if (wr_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL wdata: got unexpected write %0h, expected no write at %0t", wdata, $time);
                    end else begin
                        check("wdata", wdata, wr_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : driver
        wrst      = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        wfull     = 1'b0;
        model_reset();

        // Reset state.
        for (int i = 0; i < 3; i++) run_cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
        repeat_cycle(2, 4'b0000, 4'b0000, 1'b0);

        // Requester 0 alone: arbitration cycle, three beats ending with last, then idle.
        repeat_cycle(3, 4'b0001, 4'b0000, 1'b0);
        repeat_cycle(1, 4'b0001, 4'b0001, 1'b0);
        repeat_cycle(3, 4'b0000, 4'b0000, 1'b0);

        // All four streaming without last from a fresh pointer: 0,1,2,3,0 in MAX_BURST chunks.
        for (int i = 0; i < 2; i++) run_cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
        repeat_cycle(22, 4'b1111, 4'b0000, 1'b0);
        repeat_cycle(3, 4'b0000, 4'b0000, 1'b0);

        // Requester 1 stalled by wfull for five cycles mid-burst, then finishing with last.
        repeat_cycle(2, 4'b0010, 4'b0000, 1'b0);
        repeat_cycle(5, 4'b0010, 4'b0000, 1'b1);
        repeat_cycle(1, 4'b0010, 4'b0000, 1'b0);
        repeat_cycle(1, 4'b0010, 4'b0010, 1'b0);
        repeat_cycle(2, 4'b0000, 4'b0000, 1'b0);

        // Requester 2 goes quiet for eight cycles while 3 waits: the grant must move to 3.
        repeat_cycle(2, 4'b0100, 4'b0000, 1'b0);
        repeat_cycle(9, 4'b1000, 4'b0000, 1'b0);
        repeat_cycle(1, 4'b1000, 4'b1000, 1'b0);
        repeat_cycle(2, 4'b0000, 4'b0000, 1'b0);

        // Requester 2 quiet for only seven cycles keeps its grant.
        repeat_cycle(2, 4'b0100, 4'b0000, 1'b0);
        repeat_cycle(7, 4'b1000, 4'b0000, 1'b0);
        repeat_cycle(1, 4'b1100, 4'b0100, 1'b0);
        repeat_cycle(4, 4'b1000, 4'b1000, 1'b0);
        repeat_cycle(2, 4'b0000, 4'b0000, 1'b0);

        // Requesters 0 and 1 with 1 always ending on its first beat.
        for (int i = 0; i < 2; i++) run_cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
        repeat_cycle(14, 4'b0011, 4'b0010, 1'b0);
        repeat_cycle(2, 4'b0000, 4'b0000, 1'b0);

        // Reset in the middle of a burst from requester 3, then requester 0 must win first.
        repeat_cycle(3, 4'b1000, 4'b0000, 1'b0);
        for (int i = 0; i < 2; i++) run_cycle(4'b1001, 4'b0000, 1'b0, 1'b1);
        repeat_cycle(4, 4'b1001, 4'b0000, 1'b0);

        // Random traffic: dense valids, then sparse valids that exercise the idle timeout.
        for (int i = 0; i < 1500; i++) begin
            run_cycle(4'($urandom) | 4'($urandom),
                      ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0,
                      ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 299) == 0));
        end
        for (int i = 0; i < 1500; i++) begin
            run_cycle(4'($urandom) & 4'($urandom) & 4'($urandom),
                      4'($urandom),
                      ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 499) == 0));
        end
        repeat_cycle(2, 4'b0000, 4'b0000, 1'b0);

        @(negedge wclk);
        @(negedge wclk);
        check("writes_drained", 64'(wr_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
